// File: rtl/poly_accumulator.sv
// poly_accumulator
// Accumulates 7-lane partial-product beats into a DEPTH-coefficient polynomial
// over Z_64[x]/(x^DEPTH+1) and streams the result out on flush.
//
// Ports:
//   clk_in    - system clock
//   rst_in    - asynchronous active-low reset (also zeroes the array)
//   B_in      - packed lanes, lane k = B_in[W*k +: W]
//   idx_B     - base coefficient index of lane 0 (11 bits)
//   B_valid   - input beat valid
//   B_ready   - registered, block can accept a beat
//   clear_in  - zero the array and idx_err (taken only in IDLE)
//   flush_in  - request readout (remembered if not in IDLE)
//   out_idx   - index of out_coef
//   out_coef  - coefficient value
//   out_valid - out_coef valid
//   out_ready - downstream accepts
//   out_last  - high with coefficient DEPTH-1
//   idx_err   - sticky, a lane position was >= 2*DEPTH
module poly_accumulator #(
  parameter int DEPTH = 784,
  parameter int LANES = 7,
  parameter int W     = 6
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [LANES*W-1:0] B_in,
  input  logic [10:0]        idx_B,
  input  logic               B_valid,
  output logic               B_ready,
  input  logic               clear_in,
  input  logic               flush_in,
  output logic [9:0]         out_idx,
  output logic [W-1:0]       out_coef,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               idx_err
);

  localparam logic [11:0] DEPTH_P   = 12'(DEPTH);
  localparam logic [11:0] DEPTH2_P  = 12'(2 * DEPTH);
  localparam logic [9:0]  LAST_IDX  = 10'(DEPTH - 1);
  localparam logic [2:0]  LAST_LANE = 3'(LANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_READOUT = 2'd2
  } state_t;

  state_t               state_r, state_d;
  logic [W-1:0]         mem_r [DEPTH];
  logic [2:0]           lane_r;
  logic [9:0]           cnt_r;
  logic                 flush_pend_r, flush_pend_d;
  logic [LANES*W-1:0]   b_cap_r;
  logic [10:0]          idx_cap_r;
  logic                 idx_err_r;
  logic                 b_ready_r, b_ready_d;
  logic                 out_valid_r;
  logic [W-1:0]         out_coef_r;
  logic                 out_last_r;

  logic                 clear_take_s;
  logic                 accept_s;
  logic                 enter_rd_s;
  logic                 rd_hs_s;
  logic [9:0]           cnt_next_s;
  logic [11:0]          p_s;
  logic [11:0]          wrap_p_s;
  logic [W-1:0]         lane_val_s;
  logic                 wr_en_s;
  logic [9:0]           wr_addr_s;
  logic [W-1:0]         wr_data_s;
  logic                 err_s;

  assign B_ready   = b_ready_r;
  assign out_idx   = cnt_r;
  assign out_coef  = out_coef_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign idx_err   = idx_err_r;

  assign rd_hs_s    = (state_r == ST_READOUT) && out_valid_r && out_ready;
  assign cnt_next_s = cnt_r + 10'd1;

  // Next-state and handshake decisions; IDLE priority is clear > flush > beat.
  always_comb begin
    state_d      = state_r;
    flush_pend_d = flush_pend_r;
    clear_take_s = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clear_in) begin
          clear_take_s = 1'b1;
          // A flush coinciding with a clear is kept for the next cycle.
          flush_pend_d = flush_pend_r | flush_in;
        end else if (flush_in || flush_pend_r) begin
          state_d      = ST_READOUT;
          flush_pend_d = 1'b0;
        end else if (B_valid && b_ready_r) begin
          accept_s = 1'b1;
          state_d  = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        flush_pend_d = flush_pend_r | flush_in;
        if (lane_r == LAST_LANE) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_READOUT: begin
        flush_pend_d = flush_pend_r | flush_in;
        if (rd_hs_s && out_last_r) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READOUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Ready is offered for the next cycle only if that cycle will be an IDLE
    // cycle with nothing of higher priority waiting.
    b_ready_d = (state_d == ST_IDLE) && !flush_pend_d && !clear_take_s;
  end

  assign enter_rd_s = (state_r == ST_IDLE) && (state_d == ST_READOUT);

  // Lane position and negacyclic fold for the lane currently being added.
  assign lane_val_s = b_cap_r[lane_r*W +: W];
  assign p_s        = {1'b0, idx_cap_r} + {9'd0, lane_r};
  assign wrap_p_s   = p_s - DEPTH_P;

  // Array write port: add below DEPTH, subtract in the wrapped half, drop beyond.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = 10'd0;
    wr_data_s = {W{1'b0}};
    err_s     = 1'b0;
    if (state_r == ST_ACCUM) begin
      if (p_s < DEPTH_P) begin
        wr_en_s   = 1'b1;
        wr_addr_s = p_s[9:0];
        wr_data_s = mem_r[p_s[9:0]] + lane_val_s;
      end else if (p_s < DEPTH2_P) begin
        wr_en_s   = 1'b1;
        wr_addr_s = wrap_p_s[9:0];
        wr_data_s = mem_r[wrap_p_s[9:0]] - lane_val_s;
      end else begin
        err_s = 1'b1;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_d;
    end
  end

  // Coefficient array: zeroed by reset or a taken clear, else one lane write.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (clear_take_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Beat capture, lane counter, flags and the registered output stream.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      lane_r       <= 3'd0;
      cnt_r        <= 10'd0;
      flush_pend_r <= 1'b0;
      b_cap_r      <= {(LANES*W){1'b0}};
      idx_cap_r    <= 11'd0;
      idx_err_r    <= 1'b0;
      b_ready_r    <= 1'b0;
      out_valid_r  <= 1'b0;
      out_coef_r   <= {W{1'b0}};
      out_last_r   <= 1'b0;
    end else begin
      flush_pend_r <= flush_pend_d;
      b_ready_r    <= b_ready_d;

      if (accept_s) begin
        b_cap_r   <= B_in;
        idx_cap_r <= idx_B;
      end

      if (accept_s) begin
        lane_r <= 3'd0;
      end else if ((state_r == ST_ACCUM) && (lane_r != LAST_LANE)) begin
        lane_r <= lane_r + 3'd1;
      end else begin
        lane_r <= 3'd0;
      end

      if (clear_take_s) begin
        idx_err_r <= 1'b0;
      end else if (err_s) begin
        idx_err_r <= 1'b1;
      end

      if (enter_rd_s) begin
        out_valid_r <= 1'b1;
        cnt_r       <= 10'd0;
        out_coef_r  <= mem_r[0];
        out_last_r  <= (LAST_IDX == 10'd0);
      end else if (rd_hs_s) begin
        if (out_last_r) begin
          out_valid_r <= 1'b0;
          cnt_r       <= 10'd0;
          out_coef_r  <= {W{1'b0}};
          out_last_r  <= 1'b0;
        end else begin
          cnt_r      <= cnt_next_s;
          out_coef_r <= mem_r[cnt_next_s];
          out_last_r <= (cnt_next_s == LAST_IDX);
        end
      end
    end
  end

endmodule

// File: tb/tb_poly_accumulator.sv
module tb_poly_accumulator;

  localparam int DEPTH = 784;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [41:0] B_in = 42'd0;
  logic [10:0] idx_B = 11'd0;
  logic        B_valid = 1'b0;
  logic        B_ready;
  logic        clear_in = 1'b0;
  logic        flush_in = 1'b0;
  logic [9:0]  out_idx;
  logic [5:0]  out_coef;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        idx_err;

  int          total = 0;
  int          bad = 0;
  logic [5:0]  model [DEPTH];
  logic [41:0] bvec;
  bit          rdy_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  poly_accumulator dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .B_in      (B_in),
    .idx_B     (idx_B),
    .B_valid   (B_valid),
    .B_ready   (B_ready),
    .clear_in  (clear_in),
    .flush_in  (flush_in),
    .out_idx   (out_idx),
    .out_coef  (out_coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .idx_err   (idx_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 6'd0;
  endtask

  task automatic pulse_clear();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
  endtask

  // Returns at the sample point of the cycle after the handshake.
  task automatic send_beat(input logic [41:0] b, input logic [10:0] idx);
    int n;
    B_in = b;
    idx_B = idx;
    B_valid = 1'b1;
    n = 0;
    while (B_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("beat_ready_wait", {31'd0, B_ready}, 32'd1);
    tick();
    B_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (B_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("idle_ready_wait", {31'd0, B_ready}, 32'd1);
  endtask

  task automatic readout(input bit toggle, input int ncoef);
    int n;
    int e;
    int c;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("rd_start_valid", {31'd0, out_valid}, 32'd1);
    e = 0;
    c = 0;
    while (e < ncoef && c < 4000) begin
      out_ready = toggle ? rdy_seq[c % 4] : 1'b1;
      chk("rd_valid", {31'd0, out_valid}, 32'd1);
      chk("rd_idx", {22'd0, out_idx}, e);
      chk("rd_coef", {26'd0, out_coef}, {26'd0, model[e]});
      chk("rd_last", {31'd0, out_last}, (e == DEPTH - 1) ? 32'd1 : 32'd0);
      chk("rd_bready", {31'd0, B_ready}, 32'd0);
      tick();
      if (out_ready) e++;
      c++;
    end
    out_ready = 1'b0;
    chk("rd_count", e, ncoef);
    if (ncoef == DEPTH) begin
      chk("rd_done_valid", {31'd0, out_valid}, 32'd0);
      chk("rd_done_bready", {31'd0, B_ready}, 32'd1);
    end
  endtask

  initial begin
    zero_model();

    // Reset values, then registered B_ready one cycle after release.
    tick();
    chk("rst_bready", {31'd0, B_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_idx", {22'd0, out_idx}, 32'd0);
    chk("rst_out_coef", {26'd0, out_coef}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_idx_err", {31'd0, idx_err}, 32'd0);
    rst_in = 1'b1;
    chk("rel_bready_0", {31'd0, B_ready}, 32'd0);
    tick();
    chk("rel_bready_1", {31'd0, B_ready}, 32'd1);

    // Beat at 0 with lanes 1..7; B_ready low for exactly 7 cycles.
    for (int k = 0; k < 7; k++) bvec[6*k +: 6] = 6'(k + 1);
    send_beat(bvec, 11'd0);
    for (int i = 0; i < 7; i++) begin
      chk("busy_bready", {31'd0, B_ready}, 32'd0);
      tick();
    end
    chk("busy_done_bready", {31'd0, B_ready}, 32'd1);
    for (int k = 0; k < 7; k++) model[k] = 6'(k + 1);
    pulse_flush();
    readout(1'b0, DEPTH);

    // Mod-64 wrap: 63 + 2 = 1, read with a stalling consumer.
    pulse_clear();
    zero_model();
    send_beat(42'd63, 11'd0);
    send_beat(42'd2, 11'd0);
    wait_ready();
    model[0] = 6'd1;
    pulse_flush();
    readout(1'b1, DEPTH);

    // Negacyclic fold at the top of the array.
    pulse_clear();
    zero_model();
    send_beat({7{6'd5}}, 11'd780);
    wait_ready();
    chk("fold_idx_err", {31'd0, idx_err}, 32'd0);
    model[780] = 6'd5;
    model[781] = 6'd5;
    model[782] = 6'd5;
    model[783] = 6'd5;
    model[0] = 6'd59;
    model[1] = 6'd59;
    model[2] = 6'd59;
    pulse_flush();
    readout(1'b0, DEPTH);

    // Out-of-range lanes: two subtract, the rest are dropped and flagged.
    pulse_clear();
    zero_model();
    send_beat({7{6'd3}}, 11'd1566);
    wait_ready();
    chk("oor_idx_err", {31'd0, idx_err}, 32'd1);
    model[782] = 6'd61;
    model[783] = 6'd61;
    pulse_flush();
    readout(1'b0, DEPTH);
    chk("oor_idx_err_sticky", {31'd0, idx_err}, 32'd1);
    pulse_clear();
    chk("clr_idx_err", {31'd0, idx_err}, 32'd0);
    zero_model();
    pulse_flush();
    readout(1'b0, DEPTH);

    // Flush during ACCUM is serviced right after the beat completes.
    for (int k = 0; k < 7; k++) bvec[6*k +: 6] = 6'(k + 1);
    send_beat(bvec, 11'd10);
    tick();
    tick();
    pulse_flush();
    for (int i = 0; i < 4; i++) tick();
    chk("pend_bready", {31'd0, B_ready}, 32'd0);
    chk("pend_not_yet_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("pend_rd_entry", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < 7; k++) model[10 + k] = 6'(k + 1);
    readout(1'b0, DEPTH);

    // Reset mid-READOUT drops everything, array included.
    pulse_flush();
    readout(1'b0, 100);
    rst_in = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_idx", {22'd0, out_idx}, 32'd0);
    chk("midrst_bready", {31'd0, B_ready}, 32'd0);
    tick();
    rst_in = 1'b1;
    tick();
    chk("midrst_rel_bready", {31'd0, B_ready}, 32'd1);
    zero_model();
    pulse_flush();
    readout(1'b0, DEPTH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
